// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder controller.
// The master side issues operands and start; the slave side reports
// busy/done and the registered sum and carry-out.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. One full-adder cell, built from
// two half adders and an OR for the carry, is reused for every operand
// bit, LSB first, one bit per clock.

// Single-bit half adder; the building block of the shared full-adder cell.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_adder_ctrl_if.slave  bus
);

   // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   logic             load, step, last;
   logic             ha0_s, ha0_c, ha1_s, ha1_c, cell_co;
   logic [WIDTH:0]   res_wide;
   logic [WIDTH-1:0] res_next;

   // Shared full-adder cell: LSBs of both operands plus the stored carry.
   half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(ha0_s), .c(ha0_c));
   half_adder u_ha1 (.x(ha0_s),   .y(carry_q), .s(ha1_s), .c(ha1_c));
   assign cell_co = ha0_c | ha1_c;

   // New sum bit enters at the MSB while the result register shifts right;
   // the extra top bit keeps the slice legal for WIDTH=1.
   assign res_wide = {ha1_s, res_sr};
   assign res_next = res_wide[WIDTH:1];
   assign last     = (cnt_q == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // values that were present before the edge, so block order never matters.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and Moore outputs; unused encodings fall back to IDLE.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      load     = 1'b0;
      step     = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bus.busy = 1'b1;
            step     = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand/result shifting, carry and bit counter; outputs load on the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (load) begin
         a_sr    <= bus.a;
         b_sr    <= bus.b;
         res_sr  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (step) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         res_sr  <= res_next;
         carry_q <= cell_co;
         cnt_q   <= cnt_q + CW'(1);
         if (last) begin
            sum_q  <= res_next;
            cout_q <= cell_co;
         end
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance driven by
// directed vectors with a scoreboard monitor, plus a 1-bit instance.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst, rst1;

   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

   serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst),  .bus(bus8.slave));
   serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   logic [8:0] exp_prev;
   int         done_cnt = 0;
   int         busy_cnt = 0;
   logic       prev_busy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse of the 8-bit instance.
   always @(negedge clk) begin
      check("busy_done_exclusive", {63'd0, bus8.busy & bus8.done}, 64'd0);
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (bus8.busy) busy_cnt++;
         if (bus8.done) begin
            done_cnt++;
            check("busy_len", busy_cnt, 8);
            check("done_after_busy", {63'd0, prev_busy}, 64'd1);
            busy_cnt = 0;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("result", {55'd0, bus8.cout, bus8.sum}, {55'd0, e});
            end
         end
      end
      prev_busy = bus8.busy;
   end

   // Launch one add from IDLE and wait for its done pulse; called at a negedge.
   task automatic run_add(input logic [7:0] x, input logic [7:0] y);
      int n;
      n = 0;
      while ((bus8.busy || bus8.done) && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus8.start = 1'b1;
      bus8.a     = x;
      bus8.b     = y;
      exp_q.push_back({1'b0, x} + {1'b0, y});
      @(negedge clk);
      bus8.start = 1'b0;
      check("busy_after_start", {63'd0, bus8.busy}, 64'd1);
      check("hold_while_busy", {55'd0, bus8.cout, bus8.sum}, {55'd0, exp_prev});
      exp_prev = {1'b0, x} + {1'b0, y};
      n = 0;
      while (!bus8.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("done_timeout", 64'd1, 64'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, dones, last, cyc, dc0;
      rst = 1'b1; rst1 = 1'b1;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
      exp_prev = 9'h000;
      repeat (3) @(negedge clk);

      // Reset state of both instances.
      check("rst_busy", {63'd0, bus8.busy}, 64'd0);
      check("rst_done", {63'd0, bus8.done}, 64'd0);
      check("rst_sum",  {55'd0, bus8.cout, bus8.sum}, 64'd0);
      check("rst1_out", {60'd0, bus1.busy, bus1.done, bus1.cout, bus1.sum}, 64'd0);
      rst = 1'b0; rst1 = 1'b0;

      // WIDTH=1: 1+1 -> busy one cycle, then done with sum=0, cout=1.
      bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1_busy", {62'd0, bus1.busy, bus1.done}, 64'b10);
      @(negedge clk);
      check("w1_done", {60'd0, bus1.busy, bus1.done, bus1.cout, bus1.sum}, 64'b0110);
      @(negedge clk);
      check("w1_hold", {60'd0, bus1.busy, bus1.done, bus1.cout, bus1.sum}, 64'b0010);

      // Directed adds.
      run_add(8'h5A, 8'h3C);
      run_add(8'hFF, 8'h01);
      run_add(8'hFF, 8'hFF);
      run_add(8'h00, 8'h00);
      run_add(8'h7F, 8'h01);

      // Starts during SHIFT cycles 3 and 5 and during DONE are ignored.
      dc0 = done_cnt;
      bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02;
      exp_q.push_back(9'h003);
      @(negedge clk); bus8.start = 1'b0;           // SHIFT cycle 1
      @(negedge clk);                              // cycle 2
      @(negedge clk); bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;  // cycle 3
      @(negedge clk); bus8.start = 1'b0;           // cycle 4
      @(negedge clk); bus8.start = 1'b1;           // cycle 5
      @(negedge clk); bus8.start = 1'b0;           // cycle 6
      n = 0;
      while (!bus8.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("ign_done_timeout", 64'd1, 64'd0);
      bus8.start = 1'b1;                           // during DONE
      @(negedge clk); bus8.start = 1'b0;
      repeat (12) @(negedge clk);
      check("ign_single_done", done_cnt - dc0, 1);
      check("ign_idle", {63'd0, bus8.busy}, 64'd0);
      check("ign_sum", {55'd0, bus8.cout, bus8.sum}, 64'h003);
      exp_prev = 9'h003;

      // Reset in SHIFT cycle 4 aborts the add without a done pulse.
      bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20;
      @(negedge clk); bus8.start = 1'b0;           // cycle 1
      repeat (3) @(negedge clk);                   // cycle 4
      rst = 1'b1;
      @(negedge clk);
      check("abort_out", {53'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum}, 64'd0);
      rst = 1'b0;
      exp_prev = 9'h000;
      run_add(8'h10, 8'h20);

      // start held high: relaunch every WIDTH+2 cycles, outputs stable between.
      repeat (3) exp_q.push_back(9'h100);
      bus8.a = 8'h80; bus8.b = 8'h80; bus8.start = 1'b1;
      dones = 0; last = 0; cyc = 0;
      while (dones < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus8.done) begin
            if (dones > 0) check("relaunch_spacing", cyc - last, 10);
            last = cyc;
            dones++;
            if (dones == 3) bus8.start = 1'b0;
         end else if (dones > 0) begin
            check("hold_between_dones", {55'd0, bus8.cout, bus8.sum}, 64'h100);
         end
      end
      if (dones < 3) check("relaunch_timeout", 64'd1, 64'd0);
      repeat (12) @(negedge clk);
      check("final_idle", {62'd0, bus8.busy, bus8.done}, 64'd0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
